// File: rtl/ring_collector_if.sv
// Collector-side bundle: ring stream capture inputs plus the host-facing valid/ready drain and status.
// The master drives y_in/en/out_ready; the slave (collector) drives data, valid and status.
interface ring_collector_if #(
    parameter int PERIOD = 4,
    parameter int DEPTH  = 4
);
    logic [15:0]                 y_in;
    logic                        en;
    logic [15:0]                 out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [$clog2(DEPTH):0]      level;
    logic                        overflow;
    logic [$clog2(PERIOD)-1:0]   phase;

    modport master (
        output y_in, en, out_ready,
        input  out_data, out_valid, level, overflow, phase
    );

    modport slave (
        input  y_in, en, out_ready,
        output out_data, out_valid, level, overflow, phase
    );
endinterface

// File: rtl/ring_collector.sv
// Samples one ring result word per period (after SKIP warm-up slots) into a FIFO; head visible one cycle after capture.
// Sink stalls via out_ready; a kept word arriving with the FIFO full and no pop is dropped and flags sticky overflow.
module ring_collector #(
    parameter int PERIOD       = 4,
    parameter int RESULT_PHASE = 3,
    parameter int SKIP         = 1,
    parameter int DEPTH        = 4
) (
    input  logic            clk,
    input  logic            reset,
    ring_collector_if.slave bus
);
    localparam int PW = $clog2(PERIOD);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [PW-1:0] r_phase;
    logic [3:0]    r_skip;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;

    logic w_slot;
    logic w_keep;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_slot = (r_phase == PW'(RESULT_PHASE)) && bus.en;
    assign w_keep = w_slot && (r_skip == 4'd0);
    assign w_full = (r_level == LW'(DEPTH));
    assign w_pop  = (r_level != '0) && bus.out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_push = w_keep && (!w_full || w_pop);
    assign w_drop = w_keep && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase <= '0;
        end else if (r_phase == PW'(PERIOD - 1)) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PW'(1);
        end
    end

    // Disabled slots do not consume the warm-up budget.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_skip <= 4'(SKIP);
        end else if (w_slot && (r_skip != 4'd0)) begin
            r_skip <= r_skip - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= bus.y_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_valid = (r_level != '0);
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.phase     = r_phase;
endmodule

// File: tb/tb_ring_collector.sv
// Scoreboard bench for ring_collector: kept slot words are queued when driven and compared on each pop.
module tb_ring_collector;
    localparam int PERIOD       = 4;
    localparam int RESULT_PHASE = 3;
    localparam int SKIP         = 1;
    localparam int DEPTH        = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    ring_collector_if #(.PERIOD(PERIOD), .DEPTH(DEPTH)) bus ();

    ring_collector #(
        .PERIOD(PERIOD), .RESULT_PHASE(RESULT_PHASE), .SKIP(SKIP), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    int          skip_left = SKIP;
    bit          exp_ovf = 1'b0;
    logic [15:0] q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit rsel(input int mode, input bit slot);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (k % 3) == 0;
            default: return slot;
        endcase
    endfunction

    // Called at a falling edge: check state left by the last rising edge, then drive the next cycle.
    task automatic cyc(input logic [15:0] y, input bit e, input bit r);
        bit slot;
        chk("phase", 32'(bus.phase), 32'(k % PERIOD));
        chk("level", 32'(bus.level), 32'(q.size()));
        chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
        chk("valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0 && r) begin
            chk("data", 32'(bus.out_data), 32'(q.pop_front()));
        end
        slot = e && ((k % PERIOD) == RESULT_PHASE);
        if (slot) begin
            if (skip_left > 0) skip_left--;
            else if (q.size() < DEPTH) q.push_back(y);
            else exp_ovf = 1'b1;
        end
        bus.y_in      = y;
        bus.en        = e;
        bus.out_ready = r;
        k++;
        @(negedge clk);
    endtask

    task automatic period(input logic [15:0] v, input int rmode);
        while ((k % PERIOD) != RESULT_PHASE) cyc(~v, 1'b1, rsel(rmode, 1'b0));
        cyc(v, 1'b1, rsel(rmode, 1'b1));
    endtask

    task automatic drain(input int rmode);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            cyc(16'h0, 1'b0, rsel(rmode, 1'b0));
            n++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b0;
        bus.en        = 1'b1;
        bus.out_ready = 1'b1;
        bus.y_in      = 16'hBEEF;
        @(negedge clk);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_phase", 32'(bus.phase), 32'd0);
        q.delete();
        skip_left = SKIP;
        exp_ovf   = 1'b0;
        k         = 0;
        reset     = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.y_in = 16'h0; bus.en = 1'b0; bus.out_ready = 1'b0;

        // Basic extraction: 0x1003 discarded, 0x1007 visible one cycle after its slot edge.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (k == 4) chk("t1_skip_valid", 32'(bus.out_valid), 32'd0);
            if (k == 8) chk("t1_first_word", 32'(bus.out_data), 32'h1007);
            cyc(16'h1000 + 16'(k), 1'b1, 1'b1);
        end
        drain(1);

        // SKIP/en: disabled slots are not counted; first enabled slot is discarded.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (k == 12) chk("t2_skip_valid", 32'(bus.out_valid), 32'd0);
            if (k == 16) chk("t2_first_word", 32'(bus.out_data), 32'h200F);
            cyc(16'h2000 + 16'(k), k >= 8, 1'b1);
        end
        drain(1);

        // Fill and overflow.
        do_reset();
        period(16'hFFFF, 0);
        for (int i = 1; i <= 5; i++) begin
            period(16'(i), 0);
            chk("t3_level", 32'(bus.level), (i < 4) ? 32'(i) : 32'd4);
            chk("t3_overflow", 32'(bus.overflow), (i == 5) ? 32'd1 : 32'd0);
        end
        chk("t3_head", 32'(bus.out_data), 32'd1);
        drain(1);

        // Push and pop together while full.
        do_reset();
        period(16'hFFFF, 0);
        for (int i = 1; i <= 4; i++) period(16'(i), 0);
        period(16'd9, 3);
        chk("t4_level", 32'(bus.level), 32'd4);
        chk("t4_overflow", 32'(bus.overflow), 32'd0);
        chk("t4_head", 32'(bus.out_data), 32'd2);
        drain(1);

        // Pointer wrap under a 1-in-3 ready sink.
        do_reset();
        period(16'hFFFF, 2);
        for (int i = 0; i < 10; i++) period(16'h3000 + 16'(i), 2);
        drain(2);

        // Reset mid-operation with level=3 and overflow=1.
        do_reset();
        period(16'hFFFF, 0);
        for (int i = 1; i <= 5; i++) period(16'h50 + 16'(i), 0);
        cyc(16'h0, 1'b0, 1'b1);
        chk("t6_pre_level", 32'(bus.level), 32'd3);
        chk("t6_pre_overflow", 32'(bus.overflow), 32'd1);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (k == 4) chk("t6_skip_valid", 32'(bus.out_valid), 32'd0);
            if (k == 8) chk("t6_first_word", 32'(bus.out_data), 32'h4007);
            cyc(16'h4000 + 16'(k), 1'b1, 1'b1);
        end
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
